// File: rtl/elpis_print_pkg.sv
// Shared definitions for the Elpis print outbox: register offsets, bit indices, bus FSM states.
// Pure declarations; no timing or flow control of its own.
package elpis_print_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int ST_CNT_LSB   = 0;
    localparam int ST_CNT_W     = 5;
    localparam int ST_EMPTY     = 6;
    localparam int ST_FULL      = 7;
    localparam int ST_UNDERFLOW = 8;

    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_UNDER = 1;
    localparam int CTRL_CLR_IRQ   = 2;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

    function automatic logic [31:0] pack_status(
        input logic                underflow,
        input logic                full,
        input logic                empty,
        input logic [ST_CNT_W-1:0] count
    );
        logic [31:0] s;
        s = '0;
        s[ST_CNT_LSB +: ST_CNT_W] = count;
        s[ST_EMPTY]               = empty;
        s[ST_FULL]                = full;
        s[ST_UNDERFLOW]           = underflow;
        return s;
    endfunction

endpackage

// File: rtl/elpis_print_fifo.sv
// Generic show-ahead FIFO: dout is the head entry, a push is visible one cycle later.
// Push while full and pop while empty are ignored; flush empties it and overrides both.
module elpis_print_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/elpis_print_outbox.sv
// Queues Elpis core print values for Wishbone reads; each access acks one cycle after its strobe.
// print_ready = !full from registered count; optional irq_o under PRINT_IRQ_EN.
module elpis_print_outbox
    import elpis_print_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        print_valid,
    input  logic [31:0] print_data,
    output logic        print_ready,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        la_print_pending
`ifdef PRINT_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic              hit;
    logic              acc;
    logic [1:0]        off;
    logic              rd_data;
    logic              ctrl_wr;
    logic              flush;
    logic              pop;
    logic              push;
    logic              underflow;
    logic [31:0]       rd_dat;
    logic [31:0]       rd_mux;
    logic [31:0]       status_word;
    logic [31:0]       fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign off = wbs_adr_i[3:2];
    // Offset 0xC stays unclaimed so another slave may decode it.
    assign hit = wbs_cyc_i && wbs_stb_i &&
                 (wbs_adr_i[31:4] == BASE_ADDR[31:4]) && (off != 2'b11);
    assign acc = (state == WB_IDLE) && hit;

    assign rd_data = acc && !wbs_we_i && (off == OFF_DATA[3:2]);
    assign ctrl_wr = acc && wbs_we_i && (off == OFF_CTRL[3:2]) && wbs_sel_i[0];
    assign flush   = ctrl_wr && wbs_dat_i[CTRL_FLUSH];
    assign pop     = rd_data && !fifo_empty;

    assign print_ready      = !fifo_full;
    assign push             = print_valid && print_ready;
    assign la_print_pending = !fifo_empty;

    elpis_print_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .din   (print_data),
        .pop   (pop),
        .flush (flush),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign status_word = pack_status(underflow, fifo_full, fifo_empty, ST_CNT_W'(fifo_count));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= WB_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: if (hit) state_nxt = WB_ACK;
            WB_ACK:  state_nxt = WB_IDLE;
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = 1'b0;
        wbs_dat_o = '0;
        if (state == WB_ACK) begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = rd_dat;
        end
    end

    // Read data is captured on the accepting edge, together with the pop it causes.
    always_comb begin
        rd_mux = '0;
        if (!wbs_we_i) begin
            if (off == OFF_DATA[3:2])        rd_mux = fifo_empty ? 32'h0 : fifo_dout;
            else if (off == OFF_STATUS[3:2]) rd_mux = status_word;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)  rd_dat <= '0;
        else if (acc)  rd_dat <= rd_mux;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                                    underflow <= 1'b0;
        else if (rd_data && fifo_empty)                  underflow <= 1'b1;
        else if (ctrl_wr && wbs_dat_i[CTRL_CLR_UNDER])   underflow <= 1'b0;
    end

`ifdef PRINT_IRQ_EN
    logic irq_q;

    // A push into an empty FIFO is the 0->1 count crossing; a same-edge clear loses to it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                                  irq_q <= 1'b0;
        else if (push && fifo_empty && !flush)         irq_q <= 1'b1;
        else if (ctrl_wr && wbs_dat_i[CTRL_CLR_IRQ])   irq_q <= 1'b0;
    end

    assign irq_o = irq_q;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:3], wbs_sel_i[3:1]};
`else
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:2], wbs_sel_i[3:1]};
`endif

endmodule

// File: tb/tb_elpis_print_outbox.sv
// Scoreboard bench for elpis_print_outbox: a queue model predicts every Wishbone read.
module tb_elpis_print_outbox;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic        print_valid;
    logic [31:0] print_data;
    logic        print_ready;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        pending;
`ifdef PRINT_IRQ_EN
    logic        irq_o;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    bit          m_under = 0;
    bit          m_irq   = 0;

    elpis_print_outbox #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .print_valid      (print_valid),
        .print_data       (print_data),
        .print_ready      (print_ready),
        .wbs_cyc_i        (cyc),
        .wbs_stb_i        (stb),
        .wbs_we_i         (we),
        .wbs_sel_i        (sel),
        .wbs_adr_i        (adr),
        .wbs_dat_i        (dat_w),
        .wbs_ack_o        (ack),
        .wbs_dat_o        (dat_r),
        .la_print_pending (pending)
`ifdef PRINT_IRQ_EN
        ,
        .irq_o            (irq_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {23'b0, m_under, (mq.size() == DEPTH), (mq.size() == 0), 1'b0, 5'(mq.size())};
    endfunction

    task automatic irq_chk(input string tag);
`ifdef PRINT_IRQ_EN
        chk(tag, irq_o, m_irq);
`else
        if (tag.len() == 0) $display("irq check skipped");
`endif
    endtask

    task automatic push_val(input logic [31:0] v);
        bit take;
        @(posedge clk); #1;
        print_valid = 1'b1;
        print_data  = v;
        @(negedge clk);
        take = (mq.size() < DEPTH);
        chk("push_rdy", print_ready, take);
        @(posedge clk);
        if (take) begin
            if (mq.size() == 0) m_irq = 1;
            mq.push_back(v);
        end
        #1 print_valid = 1'b0;
        @(negedge clk);
        chk("push_pend", pending, (mq.size() != 0));
    endtask

    // One Wishbone access; pv/pd optionally present a print value on the accepting edge.
    task automatic wb_cycle(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input logic pv, input logic [31:0] pd);
        logic [31:0] e;
        logic [3:0]  off;
        bit          ready;
        bit          pre_empty;
        bit          flushed;
        bit          seen;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        print_valid = pv; print_data = pd;
        ready     = (mq.size() < DEPTH);
        pre_empty = (mq.size() == 0);
        flushed   = 0;
        off       = a[3:0];
        e         = 32'h0;
        if (!w) begin
            if (off == 4'h0) begin
                if (mq.size() > 0) e = mq.pop_front();
                else m_under = 1;
            end else if (off == 4'h4) begin
                e = status_exp();
            end
        end else if (off == 4'h8 && s[0]) begin
            if (d[2]) m_irq = 0;
            if (d[1]) m_under = 0;
            if (d[0]) begin
                mq.delete();
                flushed = 1;
            end
        end
        if (pv && ready && !flushed) begin
            if (pre_empty) m_irq = 1;
            mq.push_back(pd);
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        print_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        e = exp_q.pop_front();
        if (!seen) chk({tag, "_ack"}, ack, 1);
        else if (!w) chk(tag, dat_r, e);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, "_ack1cyc"}, ack, 0);
        chk({tag, "_datz"}, dat_r, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        wb_cycle(tag, 1'b0, a, 32'h0, 4'hF, 1'b0, 32'h0);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        wb_cycle(tag, 1'b1, a, d, s, 1'b0, 32'h0);
    endtask

    task automatic wb_noack(input string tag, input logic [31:0] a);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(tag, ack, 0);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    logic [31:0] e3;

    initial begin
        rst = 1'b1; print_valid = 1'b0; print_data = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_r, 0);
        chk("rst_rdy", print_ready, 1);
        chk("rst_pend", pending, 0);
        irq_chk("rst_irq");
        @(posedge clk); #1 rst = 1'b0;

        // 1: single value round trip
        push_val(32'h2);
        irq_chk("t1_irq_set");
        rd("t1_data", BASE + 32'h0);
        rd("t1_status", BASE + 32'h4);
        chk("t1_status_lit", status_exp(), 32'h40);
        wr("t1_irqclr", BASE + 32'h8, 32'h4, 4'hF);
        irq_chk("t1_irq_clr");

        // 2: fill to DEPTH, extra push must stall, drain in order
        push_val(32'hA); push_val(32'hB); push_val(32'hC); push_val(32'hD);
        @(negedge clk);
        chk("t2_rdy_full", print_ready, 0);
        push_val(32'hEE);
        rd("t2_status", BASE + 32'h4);
        for (int i = 0; i < 4; i++) rd("t2_data", BASE);
        irq_chk("t2_irq");

        // 3: push held while full, concurrent DATA read frees a slot
        push_val(32'hA); push_val(32'hB); push_val(32'hC); push_val(32'hD);
        @(posedge clk); #1;
        print_valid = 1'b1; print_data = 32'hE;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        exp_q.push_back(mq.pop_front());
        @(negedge clk);
        chk("t3_rdy0", print_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        e3 = exp_q.pop_front();
        chk("t3_ack", ack, 1);
        chk("t3_data", dat_r, e3);
        chk("t3_rdy1", print_ready, 1);
        @(posedge clk);
        mq.push_back(32'hE);
        #1;
        print_valid = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("t3_rdy_full", print_ready, 0);
        rd("t3_status", BASE + 32'h4);
        for (int i = 0; i < 4; i++) rd("t3_drain", BASE);

        // 4: underflow is sticky until cleared
        rd("t4_data_empty", BASE);
        rd("t4_status_uf", BASE + 32'h4);
        chk("t4_status_lit", status_exp(), 32'h140);
        wr("t4_clr", BASE + 32'h8, 32'h2, 4'hF);
        rd("t4_status", BASE + 32'h4);

        // 5: flush beats a same-cycle push; sel and ignored writes
        push_val(32'h1); push_val(32'h2); push_val(32'h3);
        wr("t5_nosel", BASE + 32'h8, 32'h1, 4'hE);
        wr("t5_wdata", BASE + 32'h0, 32'h99, 4'hF);
        rd("t5_status3", BASE + 32'h4);
        rd("t5_ctrl_rd", BASE + 32'h8);
        wb_cycle("t5_flush", 1'b1, BASE + 32'h8, 32'h1, 4'hF, 1'b1, 32'h55);
        chk("t5_pend", pending, 0);
        rd("t5_status", BASE + 32'h4);
        wb_noack("t5_off_c", BASE + 32'hC);
        wb_noack("t5_out_win", BASE + 32'h10);

        // 6: reset in the ACK cycle discards everything
        push_val(32'h77); push_val(32'h88);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_ack", ack, 1);
        rst = 1'b1;
        #1;
        chk("t6_ack_drop", ack, 0);
        chk("t6_pend", pending, 0);
        mq.delete(); m_under = 0; m_irq = 0;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        rd("t6_status", BASE + 32'h4);
        chk("t6_status_lit", status_exp(), 32'h40);
        irq_chk("t6_irq");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
